// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and small-sigma helpers for the block sequencer.
package sha256_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, KICK, ROUND, UPDATE} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0_small(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1_small(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule.sv
// 16-word circular message buffer; yields W[t] and overwrites slot t%16 with it each round.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic [5:0]  t,
  input  logic        load_en,
  input  logic [3:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic        step_en,
  output logic [31:0] w
);

  logic [31:0] msg_buf [16];
  logic [3:0]  slot;
  logic [3:0]  slot_m2;
  logic [3:0]  slot_m7;
  logic [3:0]  slot_m15;

  // Slot arithmetic wraps naturally in 4 bits, giving the mod-16 window into W[t-16..t-1].
  always_comb begin
    slot     = t[3:0];
    slot_m2  = slot - 4'd2;
    slot_m7  = slot - 4'd7;
    slot_m15 = slot - 4'd15;
    if (t < 6'd16) begin
      w = msg_buf[slot];
    end else begin
      w = sigma1_small(msg_buf[slot_m2]) + msg_buf[slot_m7]
        + sigma0_small(msg_buf[slot_m15]) + msg_buf[slot];
    end
  end

  // For t < 16 the write-back rewrites the same word, so one write path serves every round.
  always_ff @(posedge clk) begin
    if (load_en) begin
      msg_buf[load_addr] <= load_data;
    end else if (step_en) begin
      msg_buf[slot] <= w;
    end
  end

endmodule

// File: rtl/sha256_block_sequencer.sv
// Runs one SHA-256 compression per 512-bit block around an external one-round-per-cycle unit
// and folds the result into the chaining value H0..H7.
module sha256_block_sequencer
  import sha256_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              start,
  input  logic [DATA_W-1:0] msg_data,
  input  logic              msg_valid,
  output logic              msg_ready,
  output logic              busy,
  output logic              done,
  output logic [255:0]      digest,
  output logic              rnd_run,
  output logic              rnd_running,
  output logic [DATA_W-1:0] rnd_delay,
  output logic [255:0]      rnd_state,
  output logic [DATA_W-1:0] rnd_w,
  output logic [DATA_W-1:0] rnd_k,
  input  logic [255:0]      rnd_result
);

  state_t             state_q;
  state_t             state_d;
  logic [3:0]         cnt_q;
  logic [5:0]         t_q;
  logic [DATA_W-1:0]  h_q [8];
  logic               done_q;
  logic               handshake;
  logic               last_round;
  logic [DATA_W-1:0]  w;

  assign handshake  = msg_valid && msg_ready;
  assign last_round = (t_q == 6'(ROUNDS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (handshake && cnt_q == 4'd15) state_d = KICK;
      KICK:    state_d = ROUND;
      ROUND:   if (last_round) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      t_q     <= 6'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == UPDATE);
      if (state_q == IDLE) begin
        cnt_q <= 4'd0;
      end else if (handshake) begin
        cnt_q <= cnt_q + 4'd1;
      end
      if (state_q == KICK) begin
        t_q <= 6'd0;
      end else if (state_q == ROUND) begin
        t_q <= t_q + 6'd1;
      end
    end
  end

  // Chaining value: IV on reset or init in IDLE, accumulate the round-unit output in UPDATE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) h_q[i] <= IV[i];
    end else if (state_q == IDLE && init) begin
      for (int i = 0; i < 8; i++) h_q[i] <= IV[i];
    end else if (state_q == UPDATE) begin
      for (int i = 0; i < 8; i++) begin
        h_q[i] <= h_q[i] + rnd_result[255 - DATA_W*i -: DATA_W];
      end
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_digest
    assign digest[255 - DATA_W*i -: DATA_W] = h_q[i];
  end

  sha256_msg_schedule u_schedule (
    .clk       (clk),
    .t         (t_q),
    .load_en   (handshake),
    .load_addr (cnt_q),
    .load_data (msg_data),
    .step_en   (state_q == ROUND),
    .w         (w)
  );

  // The unit takes its init path on the first ROUND cycle, so running stays low while t is 0.
  assign msg_ready   = (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign rnd_run     = (state_q == KICK);
  assign rnd_running = (state_q == ROUND) && (t_q != 6'd0);
  assign rnd_delay   = '0;
  assign rnd_state   = digest;
  assign rnd_w       = w;
  assign rnd_k       = K[t_q];

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Scoreboard bench: stimulus queues expected digests, a monitor checks each done and round-unit timing.
module tb_sha256_block_sequencer;

  localparam logic [255:0] IV_ALL =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIGEST =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk = 1'b0;
  logic         rst;
  logic         init;
  logic         start;
  logic [31:0]  msg_data;
  logic         msg_valid;
  logic         msg_ready;
  logic         busy;
  logic         done;
  logic [255:0] digest;
  logic         rnd_run;
  logic         rnd_running;
  logic [31:0]  rnd_delay;
  logic [255:0] rnd_state;
  logic [31:0]  rnd_w;
  logic [31:0]  rnd_k;
  logic [255:0] rnd_result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [255:0] digest;
    bit           chk_digest;
    logic [31:0]  w16;
    bit           chk_w16;
    bit           chk_lat;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] abc_words [16];
  logic [31:0] two_a [16];
  logic [31:0] two_b [16];

  sha256_block_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .init        (init),
    .start       (start),
    .msg_data    (msg_data),
    .msg_valid   (msg_valid),
    .msg_ready   (msg_ready),
    .busy        (busy),
    .done        (done),
    .digest      (digest),
    .rnd_run     (rnd_run),
    .rnd_running (rnd_running),
    .rnd_delay   (rnd_delay),
    .rnd_state   (rnd_state),
    .rnd_w       (rnd_w),
    .rnd_k       (rnd_k),
    .rnd_result  (rnd_result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] w,
                                             input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  // Behavioural round unit: init path from in0..in7 while not running, else iterate its own state.
  logic [255:0] model_q = '0;
  always @(posedge clk) model_q <= sha_round(rnd_running ? model_q : rnd_state, rnd_w, rnd_k);
  assign rnd_result = model_q;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic waitDone();
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done) checkOutput("done_timeout", 256'd0, 256'd1);
  endtask

  task automatic applyStimulus(input logic [31:0] words [16], input int max_gap, input bit glitch,
                               input bit with_init, input bit abort, input logic [255:0] exp_digest,
                               input bit chk_digest, input bit chk_w16);
    exp_t e;
    int gap;
    int tries;
    if (!abort) begin
      e.digest = exp_digest;
      e.chk_digest = chk_digest;
      e.w16 = 32'h61626380;
      e.chk_w16 = chk_w16;
      e.chk_lat = (max_gap == 0) && !glitch;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b1;
    init  = with_init;
    @(negedge clk);
    start = 1'b0;
    init  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        msg_valid = 1'b0;
        @(negedge clk);
      end
      msg_valid = 1'b1;
      msg_data  = words[i];
      tries = 0;
      while (!msg_ready && tries < 50) begin
        @(negedge clk);
        tries++;
      end
      if (!msg_ready) checkOutput("ready_timeout", 256'd0, 256'd1);
      @(negedge clk);
    end
    msg_valid = glitch;
    msg_data  = 32'hdeadbeef;
    if (abort) begin
      tries = 0;
      while (!rnd_run && tries < 50) begin
        @(negedge clk);
        tries++;
      end
      if (!rnd_run) checkOutput("run_timeout", 256'd0, 256'd1);
      repeat (31) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_ready", 256'(msg_ready), 256'd0);
      checkOutput("abort_busy", 256'(busy), 256'd0);
      checkOutput("abort_done", 256'(done), 256'd0);
      checkOutput("abort_run", 256'(rnd_run), 256'd0);
      checkOutput("abort_running", 256'(rnd_running), 256'd0);
      checkOutput("abort_digest", digest, IV_ALL);
      rst = 1'b0;
      msg_valid = 1'b0;
      return;
    end
    if (glitch) begin
      tries = 0;
      while (!rnd_running && tries < 50) begin
        @(negedge clk);
        tries++;
      end
      repeat (3) @(negedge clk);
      start = 1'b1;
      init  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      init  = 1'b0;
    end
    waitDone();
    msg_valid = 1'b0;
  endtask

  // Monitor: samples 1 time unit after each edge, so inputs seen are those the edge captured.
  int  lat, hs, extra, run_cnt, running_cnt, first_running, cyc;
  bit  lat_on, in_blk, prev_ready, prev_busy;
  logic [31:0] w16_seen;
  exp_t cur;

  task automatic clearStats();
    lat = 0; lat_on = 0; hs = 0; extra = 0; run_cnt = 0; running_cnt = 0;
    first_running = -1; cyc = 0; in_blk = 0; w16_seen = 32'hx;
  endtask

  initial begin
    clearStats();
    prev_ready = 0;
    prev_busy = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        clearStats();
        prev_ready = 0;
        prev_busy = 0;
      end else begin
        if (busy && !prev_busy) begin
          lat = 0;
          lat_on = 1;
        end else if (lat_on) begin
          lat++;
        end
        if (msg_valid && prev_ready) hs++;
        if (msg_ready && (hs >= 16 || !busy)) extra++;
        if (in_blk) cyc++;
        if (rnd_run) begin
          run_cnt++;
          cyc = 0;
          in_blk = 1;
        end
        if (rnd_running) begin
          running_cnt++;
          if (first_running < 0) first_running = cyc;
        end
        if (in_blk && cyc == 17) w16_seen = rnd_w;
        if (done) begin
          if (exp_q.size() == 0) begin
            checkOutput("done_unexpected", 256'd1, 256'd0);
          end else begin
            cur = exp_q.pop_front();
            if (cur.chk_digest) checkOutput("digest", digest, cur.digest);
            if (cur.chk_w16) checkOutput("w16", 256'(w16_seen), 256'(cur.w16));
            if (cur.chk_lat) checkOutput("latency", 256'(lat), 256'd82);
            checkOutput("words_consumed", 256'(hs), 256'd16);
            checkOutput("ready_outside_load", 256'(extra), 256'd0);
            checkOutput("run_pulses", 256'(run_cnt), 256'd1);
            checkOutput("running_cycles", 256'(running_cnt), 256'd63);
            checkOutput("running_first", 256'(first_running), 256'd2);
            checkOutput("delay0", 256'(rnd_delay), 256'd0);
          end
          clearStats();
        end
        prev_ready = msg_ready;
        prev_busy  = busy;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      abc_words[i] = 32'h0;
      two_b[i] = 32'h0;
    end
    abc_words[0]  = 32'h61626380;
    abc_words[15] = 32'h00000018;
    two_a = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
              32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
              32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
              32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two_b[15] = 32'h000001c0;

    rst = 1'b1;
    init = 1'b0;
    start = 1'b0;
    msg_valid = 1'b0;
    msg_data = 32'h0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", 256'(msg_ready), 256'd0);
    checkOutput("reset_busy", 256'(busy), 256'd0);
    checkOutput("reset_done", 256'(done), 256'd0);
    checkOutput("reset_run", 256'(rnd_run), 256'd0);
    checkOutput("reset_running", 256'(rnd_running), 256'd0);
    checkOutput("reset_digest", digest, IV_ALL);
    rst = 1'b0;

    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    applyStimulus(abc_words, 0, 1'b0, 1'b0, 1'b0, ABC_DIGEST, 1'b1, 1'b1);

    applyStimulus(two_a, 0, 1'b0, 1'b1, 1'b0, 256'd0, 1'b0, 1'b0);
    applyStimulus(two_b, 0, 1'b0, 1'b0, 1'b0, TWO_DIGEST, 1'b1, 1'b0);

    applyStimulus(abc_words, 5, 1'b0, 1'b1, 1'b0, ABC_DIGEST, 1'b1, 1'b1);
    applyStimulus(abc_words, 0, 1'b1, 1'b1, 1'b0, ABC_DIGEST, 1'b1, 1'b1);

    applyStimulus(abc_words, 0, 1'b0, 1'b1, 1'b1, 256'd0, 1'b0, 1'b0);
    applyStimulus(abc_words, 0, 1'b0, 1'b0, 1'b0, ABC_DIGEST, 1'b1, 1'b1);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_empty", 256'(exp_q.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
